pong_ball_ctrl: RTL and testbench

PONG_BALL_CTRL -- requirements
Module: pong_ball_ctrl

---
 rtl/pong_ball_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctrl.sv
// One-dimensional pong controller: ball position, rally timing, scoring and game-over.
// Optional PONG_SPEEDUP_EN: each successful return shortens the step period by one cycle.
module pong_ball_ctrl #(
  parameter int NUM_LEDS  = 8,
  parameter int TICK_DIV  = 4,
  parameter int WIN_SCORE = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_l_rise,
  input  logic                btn_r_rise,
  output logic [NUM_LEDS-1:0] leds,
  output logic [3:0]          score_l,
  output logic [3:0]          score_r,
  output logic                game_over,
  output logic                winner
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam int CW = $clog2(TICK_DIV + 1);

  localparam logic [PW-1:0] POS_LAST   = PW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] PERIOD_MAX = CW'(TICK_DIV);
  localparam logic [CW-1:0] POINT_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic          SIDE_L     = 1'b0;
  localparam logic          SIDE_R     = 1'b1;

  typedef enum logic [2:0] {
    SERVE_L, SERVE_R, MOVE_R, MOVE_L, POINT, GAME_OVER
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          score_l_q, score_l_d;
  logic [3:0]          score_r_q, score_r_d;
  logic                scorer_q, scorer_d;
  logic                winner_q, winner_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                game_over_q, game_over_d;
  logic [CW-1:0]       period;
  logic                step;
  logic                score_pt;

  assign step = (cnt_q == period - CW'(1));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q     <= SERVE_L;
      pos_q       <= '0;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      scorer_q    <= SIDE_L;
      winner_q    <= SIDE_L;
      leds_q      <= NUM_LEDS'(1);
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      scorer_q    <= scorer_d;
      winner_q    <= winner_d;
      leds_q      <= leds_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    scorer_d  = scorer_q;
    winner_d  = winner_q;
    score_pt  = 1'b0;

    case (state_q)
      SERVE_L: begin
        pos_d = '0;
        if (btn_l_rise) begin
          state_d = MOVE_R;
          cnt_d   = '0;
        end
      end
      SERVE_R: begin
        pos_d = POS_LAST;
        if (btn_r_rise) begin
          state_d = MOVE_L;
          cnt_d   = '0;
        end
      end
      MOVE_R: begin
        if (btn_r_rise) begin
          if (pos_q == POS_LAST) begin
            state_d = MOVE_L;
            cnt_d   = '0;
          end else begin
            score_pt = 1'b1;
            scorer_d = SIDE_L;
          end
        end else if (step) begin
          cnt_d = '0;
          if (pos_q == POS_LAST) begin
            score_pt = 1'b1;
            scorer_d = SIDE_L;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MOVE_L: begin
        if (btn_l_rise) begin
          if (pos_q == '0) begin
            state_d = MOVE_R;
            cnt_d   = '0;
          end else begin
            score_pt = 1'b1;
            scorer_d = SIDE_R;
          end
        end else if (step) begin
          cnt_d = '0;
          if (pos_q == '0) begin
            score_pt = 1'b1;
            scorer_d = SIDE_R;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      POINT: begin
        if (cnt_q == POINT_LAST) begin
          cnt_d = '0;
          if ((scorer_q == SIDE_L ? score_l_q : score_r_q) == WIN) begin
            state_d  = GAME_OVER;
            winner_d = scorer_q;
          end else if (scorer_q == SIDE_L) begin
            state_d = SERVE_R;
            pos_d   = POS_LAST;
          end else begin
            state_d = SERVE_L;
            pos_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAME_OVER: begin
        if (btn_l_rise || btn_r_rise) begin
          state_d   = SERVE_L;
          pos_d     = '0;
          cnt_d     = '0;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      default: state_d = SERVE_L;
    endcase

    // Scores saturate at WIN so a stray extra point can never wrap them.
    if (score_pt) begin
      state_d = POINT;
      cnt_d   = '0;
      if (scorer_d == SIDE_L) begin
        if (score_l_q != WIN) score_l_d = score_l_q + 4'd1;
      end else begin
        if (score_r_q != WIN) score_r_d = score_r_q + 4'd1;
      end
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [CW-1:0] period_q, period_d;
  logic          ret_hit;

  always_comb begin
    ret_hit  = (state_q == MOVE_R && btn_r_rise && pos_q == POS_LAST) ||
               (state_q == MOVE_L && btn_l_rise && pos_q == '0);
    period_d = period_q;
    if (state_d == POINT && state_q != POINT) begin
      period_d = PERIOD_MAX;
    end else if (ret_hit && period_q > CW'(1)) begin
      period_d = period_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) period_q <= PERIOD_MAX;
    else     period_q <= period_d;
  end

  assign period = period_q;
`else
  assign period = PERIOD_MAX;
`endif

  // Output logic: computed from next state so every output leaves a flop.
  always_comb begin
    leds_d      = '0;
    game_over_d = 1'b0;
    case (state_d)
      SERVE_L, SERVE_R, MOVE_R, MOVE_L: leds_d[pos_d] = 1'b1;
      POINT:                            leds_d = '1;
      GAME_OVER:                        game_over_d = 1'b1;
      default:                          leds_d = '0;
    endcase
  end

  assign leds      = leds_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl (NUM_LEDS=8, TICK_DIV=4, WIN_SCORE=3).
// With PONG_SPEEDUP_EN defined the speedup sequence runs instead of the base rally.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_l_rise;
  logic       btn_r_rise;
  logic [7:0] leds;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;

  int n_checks = 0;
  int n_fail   = 0;

  pong_ball_ctrl #(
    .NUM_LEDS  (8),
    .TICK_DIV  (4),
    .WIN_SCORE (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_l_rise (btn_l_rise),
    .btn_r_rise (btn_r_rise),
    .leds       (leds),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic r);
    btn_l_rise = l;
    btn_r_rise = r;
    tick(1);
    btn_l_rise = 1'b0;
    btn_r_rise = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    btn_l_rise = 1'b0;
    btn_r_rise = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_leds", leds, 8'h01);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);

`ifdef PONG_SPEEDUP_EN
    pulse(1, 0);
    tick(28);  check("sp_at_right", leds, 8'h80);
    pulse(0, 1);                                   // return 1 -> period 3
    tick(2);   check("sp_p3_hold", leds, 8'h80);
    tick(1);   check("sp_p3_step", leds, 8'h40);
    tick(18);  check("sp_p3_left", leds, 8'h01);
    pulse(1, 0);                                   // return 2 -> period 2
    tick(14);  check("sp_p2_right", leds, 8'h80);
    pulse(0, 1);                                   // return 3 -> period 1
    tick(1);   check("sp_p1_step", leds, 8'h40);
    tick(6);   check("sp_p1_left", leds, 8'h01);
    pulse(1, 0);                                   // return 4 -> stays 1
    tick(1);   check("sp_floor_step", leds, 8'h02);
    tick(6);   check("sp_floor_right", leds, 8'h80);
    tick(1);   check("sp_miss_leds", leds, 8'hFF);
    check("sp_miss_score_l", score_l, 1);
    tick(4);   check("sp_serve_r", leds, 8'h80);
    pulse(0, 1);
    tick(3);   check("sp_restored_hold", leds, 8'h80);
    tick(1);   check("sp_restored_step", leds, 8'h40);
`else
    // Serve and rally timing
    pulse(0, 1); check("serve_l_ignores_r", leds, 8'h01);
    tick(4);     check("serve_l_idle", leds, 8'h01);
    pulse(1, 0);
    tick(3);     check("move_r_hold", leds, 8'h01);
    tick(1);     check("move_r_step1", leds, 8'h02);
    tick(23);    check("move_r_pos6", leds, 8'h40);
    tick(1);     check("move_r_pos7", leds, 8'h80);
    pulse(0, 1); check("return_r_pos", leds, 8'h80);
    tick(3);     check("move_l_hold", leds, 8'h80);
    tick(1);     check("move_l_step1", leds, 8'h40);
    tick(24);    check("move_l_pos0", leds, 8'h01);
    pulse(1, 0);
    tick(28);    check("rally_pos7", leds, 8'h80);

    // Right misses: left scores, right serves next
    tick(3);     check("miss_pending", leds, 8'h80);
    check("miss_pending_score", score_l, 0);
    tick(1);     check("miss_point_leds", leds, 8'hFF);
    check("miss_score_l", score_l, 1);
    tick(3);     check("point_hold", leds, 8'hFF);
    tick(1);     check("serve_r_leds", leds, 8'h80);
    check("serve_r_score_r", score_r, 0);

    // Early swing by right at 0x08; non-receiver swing ignored
    pulse(1, 0); check("serve_r_ignores_l", leds, 8'h80);
    pulse(0, 1);
    tick(28);    check("serve_r_to_left", leds, 8'h01);
    pulse(1, 0);
    tick(12);    check("at_0x08", leds, 8'h08);
    pulse(1, 0); check("non_receiver_leds", leds, 8'h08);
    check("non_receiver_score", score_l, 1);
    pulse(0, 1); check("early_leds", leds, 8'hFF);
    check("early_score_l", score_l, 2);
    tick(4);     check("early_serve_r", leds, 8'h80);

    // Early swing by left: right scores, left serves
    pulse(0, 1);
    pulse(1, 0); check("early_l_score_r", score_r, 1);
    check("early_l_score_l", score_l, 2);
    tick(4);     check("early_l_serve_l", leds, 8'h01);

    // Both buttons: server's pulse in SERVE_L, receiver's in MOVE_R
    pulse(1, 1); check("both_serve_leds", leds, 8'h01);
    tick(4);     check("both_serve_moving", leds, 8'h02);
    pulse(1, 1); check("both_move_leds", leds, 8'hFF);
    check("win_score_l", score_l, 3);
    tick(3);     check("win_pending", game_over, 0);
    tick(1);     check("game_over", game_over, 1);
    check("winner_left", winner, 0);
    check("game_over_leds", leds, 8'h00);
    tick(2);     check("game_over_holds", game_over, 1);
    pulse(0, 1); check("restart_leds", leds, 8'h01);
    check("restart_score_l", score_l, 0);
    check("restart_score_r", score_r, 0);
    check("restart_game_over", game_over, 0);

    // Reset during POINT
    pulse(1, 0);
    pulse(0, 1); check("pre_rst_point", leds, 8'hFF);
    tick(1);
    do_reset();
    check("rst_point_leds", leds, 8'h01);
    check("rst_point_score", score_l, 0);
    pulse(1, 0);
    tick(4);     check("rst_point_serve", leds, 8'h02);

    // Reset during MOVE_L at 0x10, with a simultaneous left pulse
    tick(24);    check("rst2_pos7", leds, 8'h80);
    pulse(0, 1);
    tick(12);    check("rst2_at_0x10", leds, 8'h10);
    btn_l_rise = 1'b1;
    do_reset();
    btn_l_rise = 1'b0;
    check("rst_move_leds", leds, 8'h01);
    check("rst_move_score_l", score_l, 0);
    check("rst_move_score_r", score_r, 0);
    tick(4);     check("rst_priority", leds, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
